// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_arbiter
// Purpose  : Round-robin write-back arbiter for the 8-bit register file
//            (ALU, scratch RAM, stack pointer, input port). Optional build
//            macro RF_ARB_STATS_EN adds the wr_cnt / conflict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter #(
  parameter int ADDR_W = 5,
  parameter int NREQ   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [NREQ-1:0]   req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  output logic [NREQ-1:0]   ack,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_adrx,
  output logic [1:0]        rf_wr_sel,
`ifdef RF_ARB_STATS_EN
  output logic [15:0]       wr_cnt,
  output logic              conflict,
`endif
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam logic [1:0] c_sel_one = 2'd1;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [NREQ-1:0]   r_ack;
  logic [ADDR_W-1:0] r_adrx;
  logic [1:0]        r_sel;

  logic [ADDR_W-1:0] w_addr [NREQ];
  logic [NREQ-1:0]   w_elig;
  logic              w_any;
  logic              w_multi;
  logic              w_grant;
  logic [1:0]        w_win;
  logic [1:0]        w_idx;
  logic              w_found;

  assign w_addr[0] = addr0;
  assign w_addr[1] = addr1;
  assign w_addr[2] = addr2;
  assign w_addr[3] = addr3;

  // The source acked this cycle is masked so a late REQ drop cannot double-grant.
  assign w_elig  = req & ~r_ack;
  assign w_any   = |w_elig;
  assign w_multi = |(w_elig & (w_elig - NREQ'(1)));
  assign w_grant = ~hold & w_any;

  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_ack   <= '0;
      r_adrx  <= '0;
      r_sel   <= 2'd0;
    end else if (w_grant) begin
      r_state <= ST_WRITE;
      r_ack   <= NREQ'(1) << w_win;
      r_adrx  <= w_addr[w_win];
      r_sel   <= w_win;
      r_ptr   <= w_win + c_sel_one;
    end else begin
      // Address and select keep their last values; only the write strobe drops.
      r_state <= ST_IDLE;
      r_ack   <= '0;
    end
  end

  assign ack       = r_ack;
  assign rf_wr     = (r_state == ST_WRITE);
  assign rf_adrx   = r_adrx;
  assign rf_wr_sel = r_sel;
  assign busy      = rst_n & w_any;

`ifdef RF_ARB_STATS_EN
  logic [15:0] r_wr_cnt;
  logic        r_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt   <= 16'd0;
      r_conflict <= 1'b0;
    end else begin
      if ((r_state == ST_WRITE) && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      r_conflict <= w_grant & w_multi;
    end
  end

  assign wr_cnt   = r_wr_cnt;
  assign conflict = r_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wr_arbiter
// Purpose  : Directed self-checking bench for rf_wr_arbiter with a cycle
//            model compared on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic [3:0] req;
  logic [4:0] addr0, addr1, addr2, addr3;
  logic [3:0] ack;
  logic       rf_wr;
  logic [4:0] rf_adrx;
  logic [1:0] rf_wr_sel;
  logic       busy;
`ifdef RF_ARB_STATS_EN
  logic [15:0] wr_cnt;
  logic        conflict;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rf_wr_arbiter #(.ADDR_W(5), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .ack(ack), .rf_wr(rf_wr), .rf_adrx(rf_adrx), .rf_wr_sel(rf_wr_sel),
`ifdef RF_ARB_STATS_EN
    .wr_cnt(wr_cnt), .conflict(conflict),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the write in flight is identified by its source index (-1 = none).
  int          m_win;
  int          m_ptr;
  logic [4:0]  m_adrx;
  int          m_sel;
  int          m_cnt;
  logic        m_conf;

  function automatic int pick(logic [3:0] r, int ptr, int masked);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr + i) % 4;
      if (r[j] && j != masked) return j;
    end
    return -1;
  endfunction

  function automatic int elig_cnt(logic [3:0] r, int masked);
    int n;
    n = 0;
    for (int j = 0; j < 4; j++) if (r[j] && j != masked) n++;
    return n;
  endfunction

  function automatic logic [4:0] addr_of(int i);
    case (i)
      0:       return addr0;
      1:       return addr1;
      2:       return addr2;
      default: return addr3;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_win  <= -1;
      m_ptr  <= 0;
      m_adrx <= 5'd0;
      m_sel  <= 0;
      m_cnt  <= 0;
      m_conf <= 1'b0;
    end else begin
      if (m_win >= 0 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      m_conf <= !hold && elig_cnt(req, m_win) >= 2;
      if (!hold && pick(req, m_ptr, m_win) >= 0) begin
        m_win  <= pick(req, m_ptr, m_win);
        m_sel  <= pick(req, m_ptr, m_win);
        m_adrx <= addr_of(pick(req, m_ptr, m_win));
        m_ptr  <= (pick(req, m_ptr, m_win) + 1) % 4;
      end else begin
        m_win <= -1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ack", 32'(ack), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
    chk("m_rf_wr", 32'(rf_wr), (m_win >= 0) ? 32'd1 : 32'd0);
    chk("m_adrx", 32'(rf_adrx), 32'(m_adrx));
    chk("m_sel", 32'(rf_wr_sel), 32'(m_sel));
    chk("m_busy", 32'(busy), (rst_n && elig_cnt(req, m_win) > 0) ? 32'd1 : 32'd0);
`ifdef RF_ARB_STATS_EN
    chk("m_wr_cnt", 32'(wr_cnt), 32'(m_cnt));
    chk("m_conflict", 32'(conflict), 32'(m_conf));
`endif
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0; req = 4'b0000;
    addr0 = 5'd0; addr1 = 5'd0; addr2 = 5'd0; addr3 = 5'd0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_rf_wr", 32'(rf_wr), 32'd0);

    // Single ALU request
    addr0 = 5'd7; req = 4'b0001;
    tick();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_rf_wr", 32'(rf_wr), 32'd1);
    chk("single_sel", 32'(rf_wr_sel), 32'd0);
    chk("single_adrx", 32'(rf_adrx), 32'd7);
    req = 4'b0000;
    tick();
    chk("single_drop_rf_wr", 32'(rf_wr), 32'd0);
    chk("single_hold_adrx", 32'(rf_adrx), 32'd7);

    // Lone SP requester alternates because of the mask
    addr2 = 5'd9; req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("sp_alt_ack", 32'(ack), (k % 2 == 0) ? 32'h4 : 32'h0);
      chk("sp_alt_busy", 32'(busy), (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    req = 4'b0000;
    tick();

    // HOLD raised right after a grant registers
    addr3 = 5'd3; req = 4'b1000;
    tick();
    chk("hold_first_ack", 32'(ack), 32'h8);
    hold = 1'b1;
    tick();
    chk("hold_blk1_ack", 32'(ack), 32'h0);
    tick();
    chk("hold_blk2_ack", 32'(ack), 32'h0);
    chk("hold_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    tick();
    chk("hold_release_ack", 32'(ack), 32'h8);
    chk("hold_release_sel", 32'(rf_wr_sel), 32'd3);
    chk("hold_release_adrx", 32'(rf_adrx), 32'd3);
    req = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a write
    addr0 = 5'd1; addr1 = 5'd2; addr2 = 5'd3; addr3 = 5'd4;
    req = 4'b1111;
    tick();
    chk("pre_rst_rf_wr", 32'(rf_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_sel", 32'(rf_wr_sel), 32'd0);
    chk("async_rst_adrx", 32'(rf_adrx), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rf_wr", 32'(rf_wr), 32'd0);
    tick();
    chk("post_rst_ack", 32'(ack), 32'd0);

    // Four continuous requesters: strict rotation with wrap-around
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_sel", 32'(rf_wr_sel), 32'(k % 4));
      chk("rr_ack", 32'(ack), 32'd1 << (k % 4));
      chk("rr_adrx", 32'(rf_adrx), 32'((k % 4) + 1));
      chk("rr_rf_wr", 32'(rf_wr), 32'd1);
    end
    req = 4'b0000;
    tick();

`ifdef RF_ARB_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req = 4'b0011;
    tick();
    chk("stats_conflict", 32'(conflict), 32'd1);
    chk("stats_ack0", 32'(ack), 32'h1);
    tick();
    chk("stats_ack1", 32'(ack), 32'h2);
    chk("stats_conflict_clr", 32'(conflict), 32'd0);
    req = 4'b0000;
    tick();
    chk("stats_wr_cnt", 32'(wr_cnt), 32'd2);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Arbitrates write-back to the 8-bit register file among four sources: ALU, scratch RAM, stack pointer and input port.
- Drives RF_WR_SEL into the register-file write-data mux, plus the register-file write enable and destination address.
- Returns a per-source acknowledge.
- Sits between the control unit / source blocks and the register file. Guarantees at most one register-file write per clock, with round-robin fairness.

Parameters:
ADDR_W, 5, register-file address width (32 registers)
NREQ, 4, number of requesters; fixed at 4, since index equals RF_WR_SEL code

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  asynchronous, active-low reset
HOLD  input  1  control-unit stall; blocks new grants while high
REQ  input  4  write request per source; bit 0 ALU, 1 SCR, 2 SP, 3 IN_PORT
ADDR0..ADDR3  input  ADDR_W each  destination register per source
ACK  output  4  one-hot; write of that source commits at the rising edge that ends this cycle
RF_WR  output  1  register-file write enable
RF_ADRX  output  ADDR_W  register-file write address
RF_WR_SEL  output  2  write-data mux select: 00 ALU, 01 SCR, 10 SP, 11 IN_PORT
BUSY  output  1  high when any unmasked REQ is pending and not being acked this cycle

Behaviour:
- Reset (RST_N low, asynchronous): RF_WR=0, ACK=0000, RF_ADRX=0, RF_WR_SEL=00, round-robin pointer PTR=0, mask=0000. BUSY is combinational and also forced 0 while RST_N is low.
- All outputs except BUSY are registered. Latency from REQ high to ACK/RF_WR is 1 cycle.
- Two states:
  - IDLE: RF_WR=0.
  - WRITE: RF_WR=1 and exactly one ACK bit set.
  - Each edge, if HOLD=0 and any eligible request exists → WRITE, else → IDLE. WRITE may repeat back-to-back for different winners.
- Eligible request: REQ[i]=1 and i is not the source being acked in the current cycle (mask).
  - This prevents a double grant while the winner drops REQ.
- Winner selection: search eligible bits starting at index PTR, ascending, modulo 4. First hit wins.
- On grant to winner w:
  - At the next edge: RF_WR_SEL←w, RF_ADRX←ADDRw, ACK←one-hot(w), RF_WR←1, PTR←(w+1) mod 4.
  - ADDR is sampled at the grant edge.
- Handshake rules:
  - A requester holds REQ, ADDRi and its data constant until it sees ACK[i]=1.
  - The data mux is combinational, so the source's data must also be valid during the ACK cycle.
  - The requester deasserts REQ or presents a new request on the following edge. A REQ still high one cycle after ACK is a new request.
- HOLD:
  - Sampled each edge. HOLD=1 blocks new grants only.
  - A write already registered (RF_WR=1 this cycle) completes.
  - PTR is unchanged while held.
- Simultaneous requests: only one is acked per cycle. Others stay pending with BUSY=1.
- A sole requester can write at most every other cycle. Four continuous requesters each win once per 4 cycles.
- Same-address requests from two sources are serialized in grant order. The last write wins; no merging.
- Wrap-around: PTR goes 3→0.
- Reset mid-WRITE aborts the write immediately, since RF_WR drops asynchronously. The requester retries after reset.
- REQ=0000 with HOLD=0: stays IDLE, outputs hold last RF_ADRX/RF_WR_SEL values, RF_WR=0.

Optional Feature:
RF_ARB_STATS_EN
- Defined: adds output WR_CNT (16 bits), reset to 0. It increments on every cycle with RF_WR=1 and saturates at 0xFFFF.
- Adds output CONFLICT (1 bit, registered). It is 1 for one cycle after any grant edge where two or more eligible REQ bits were set.
- Undefined: neither port exists; no counter logic.

Test Plan:
1. Reset: RST_N=0 asynchronously mid-cycle with RF_WR=1 → RF_WR, ACK and RF_WR_SEL go to 0 immediately. After release with REQ=0000, outputs stay idle.
2. Single request: REQ=0001, ADDR0=5'd7 held until ACK → next cycle RF_WR=1, RF_WR_SEL=00, RF_ADRX=7, ACK=0001. Drop REQ → RF_WR=0 the cycle after.
3. All four held continuously from reset → grant order ALU, SCR, SP, IN_PORT, ALU… with RF_WR_SEL=00,01,10,11,00. RF_WR high every cycle; each ACK bit high 1 in 4.
4. Lone SP requester holding REQ=0100 for 6 cycles → ACK[2] alternates 1,0,1,0 (mask). Never acked in consecutive cycles.
5. HOLD=1 asserted the same edge a grant registers, with REQ=1000 → the registered write completes (ACK=1000 for one cycle). No further grant while HOLD=1. Next grant is 1 cycle after HOLD falls.
6. With RF_ARB_STATS_EN: REQ=0011 simultaneously → CONFLICT=1 for one cycle. WR_CNT=2 after both writes. Preload near 0xFFFF → WR_CNT saturates.
